man_encoder_tx: RTL

Byte-oriented Manchester transmitter that serialises 8-bit words into a framed, IEEE 802.3-convention Manchester line signal on `clk_32Mhz`. It sits directly upstream of the Manchester decoder: its `encoded_data` drives the decoder's `encoded_data` input. The decoder samples the second half of each 16-cycle bit period, so the timing here matches that. Upstream logic supplies bytes through a valid/ready handshake.

---
 rtl/man_pkg.sv | 26 ++
 rtl/man_bit_timer.sv | 51 +++++
 rtl/man_encoder_tx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/man_pkg.sv
// Shared types and constants for the Manchester transmitter.
// Defines the transmit state encoding and the line/parity helper functions.
package man_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    GAP    = 3'd4
  } man_tx_state_t;

  localparam int   MAN_HALF_BIT_DEFAULT = 8;
  localparam logic MAN_START_BIT        = 1'b0;
  localparam logic MAN_IDLE_LEVEL       = 1'b0;

  // IEEE 802.3 convention: first half carries ~b, second half carries b.
  function automatic logic man_half_level(input logic b, input logic second_half);
    return second_half ? b : ~b;
  endfunction

  function automatic logic man_even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/man_bit_timer.sv
// Half-bit counter and phase flag for the Manchester transmitter.
// Held cleared while disabled so every frame starts on a fresh half-bit.
module man_bit_timer #(
  parameter int HALF_BIT = 8
) (
  input  logic clk_32Mhz,
  input  logic rst,
  input  logic en,
  output logic phase,
  output logic half_tick,
  output logic bit_tick
);

  localparam int            CW   = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  assign half_tick = en && (cnt_q == LAST);
  assign bit_tick  = half_tick && phase_q;
  assign phase     = phase_q;

  // Next count/phase: clear when disabled, wrap and toggle phase on each half.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (half_tick) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + CW'(1);
      phase_d = phase_q;
    end
  end

  // Counter and phase registers.
  always_ff @(posedge clk_32Mhz or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/man_encoder_tx.sv
// Byte-serial Manchester transmitter: START, 8 data bits LSB first, optional
// even parity (define MAN_TX_PARITY_EN), then GAP_BITS idle-low bit periods.
module man_encoder_tx
  import man_pkg::*;
#(
  parameter int HALF_BIT = MAN_HALF_BIT_DEFAULT,
  parameter int GAP_BITS = 2
) (
  input  logic       clk_32Mhz,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       encoded_data,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int GW = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;

  man_tx_state_t state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          encoded_q, encoded_d;
  logic          done_q, done_d;
`ifdef MAN_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic phase;
  logic half_tick;
  logic bit_tick;
  logic unused_half_tick;
  logic accept;

  assign accept           = tx_valid && (state_q == IDLE);
  assign unused_half_tick = half_tick;

  man_bit_timer #(.HALF_BIT(HALF_BIT)) u_timer (
    .clk_32Mhz (clk_32Mhz),
    .rst       (rst),
    .en        (state_q != IDLE),
    .phase     (phase),
    .half_tick (half_tick),
    .bit_tick  (bit_tick)
  );

  // Next-state and line level; the line register lags the state by one cycle.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    encoded_d = MAN_IDLE_LEVEL;
`ifdef MAN_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = START;
          shift_d  = tx_data;
          idx_d    = 3'd0;
          gap_d    = '0;
`ifdef MAN_TX_PARITY_EN
          parity_d = man_even_parity(tx_data);
`endif
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        encoded_d = man_half_level(MAN_START_BIT, phase);
        if (bit_tick) begin
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        encoded_d = man_half_level(shift_q[0], phase);
        if (bit_tick && (idx_q == 3'd7)) begin
`ifdef MAN_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = GAP;
`endif
        end else if (bit_tick) begin
          idx_d   = idx_q + 3'd1;
          shift_d = {1'b0, shift_q[7:1]};
        end else begin
          state_d = DATA;
        end
      end
`ifdef MAN_TX_PARITY_EN
      PARITY: begin
        encoded_d = man_half_level(parity_q, phase);
        if (bit_tick) begin
          state_d = GAP;
        end else begin
          state_d = PARITY;
        end
      end
`endif
      GAP: begin
        encoded_d = MAN_IDLE_LEVEL;
        // One extra cycle after the last gap tick lets the line's gap run in full.
        if (gap_q == GW'(GAP_BITS)) begin
          state_d = IDLE;
        end else if (bit_tick) begin
          gap_d = gap_q + GW'(1);
        end else begin
          state_d = GAP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    done_d = (state_q != IDLE) && (state_d == IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk_32Mhz or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      idx_q     <= 3'd0;
      gap_q     <= '0;
      encoded_q <= MAN_IDLE_LEVEL;
      done_q    <= 1'b0;
`ifdef MAN_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      encoded_q <= encoded_d;
      done_q    <= done_d;
`ifdef MAN_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx_ready     = (state_q == IDLE);
  assign tx_busy      = ~tx_ready;
  assign encoded_data = encoded_q;
  assign tx_done      = done_q;

endmodule
